// File: rtl/sram_port_arb_pkg.sv
// Shared definitions for the packet-buffer SRAM port arbiter.
// SRAM geometry, arbiter state encoding and default lock limit.
package sram_port_arb_pkg;

  localparam int SRAM_DW      = 16;
  localparam int SRAM_AW      = 14;
  localparam int DEF_MAX_LOCK = 64;
  localparam int DEF_CW       = 6;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_port_arb_rr_pick.sv
// Combinational N-way round-robin priority picker.
// Grants the first requesting index at or after ptr_i, searching with wrap-around.
module sram_port_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  int   idx;
  logic found;

  // Walk the requesters starting at the pointer and keep the first hit.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arb.sv
// Round-robin arbiter/sequencer sharing one port of the packet-buffer SRAM.
// Supports locked bursts bounded by a watchdog of MAX_LOCK cycles.
// Optional macro SRAM_ARB_OREG_EN registers the SRAM drive (+1 cycle on
// controls and on read-valid); the default build drives the SRAM combinationally.
// Handshake: a requester holds iReq (with iWr/iAddr/iWData stable) until it
// sees oGnt; the access happens in the oGnt cycle, and a read returns oRVld
// with oRData a fixed latency later. oState exposes the arbiter FSM.
module sram_port_arb
  import sram_port_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DW       = SRAM_DW,
  parameter int AW       = SRAM_AW,
  parameter int MAX_LOCK = DEF_MAX_LOCK,
  parameter int CW       = DEF_CW
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic [N-1:0]    iReq,
  input  logic [N-1:0]    iWr,
  input  logic [N-1:0]    iLock,
  input  logic [N*AW-1:0] iAddr,
  input  logic [N*DW-1:0] iWData,
  output logic [N-1:0]  oGnt,
  output logic [N-1:0]  oRVld,
  output logic [DW-1:0] oRData,
  output logic          oCEn,
  output logic          oWEn,
  output logic [DW-1:0] oBWEn,
  output logic [AW-1:0] oAddr,
  output logic [DW-1:0] oWData,
  input  logic [DW-1:0] iRData,
  output arb_state_e    oState
);

  localparam int PW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [N-1:0]  pick_gnt;
  logic [N-1:0]  gnt;
  logic [PW-1:0] g_idx;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_any;
  logic [AW-1:0] addr_d,  addr_q;
  logic [DW-1:0] wdata_d, wdata_q;
  logic [N-1:0]  rd_pend;
  logic [N-1:0]  rvld1_q;

  sram_port_arb_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req_i (iReq),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  // Next-state, grant and lock-counter logic of the arbiter FSM.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt = pick_gnt;
        if (|pick_gnt) begin
          if (iLock[g_idx]) begin
            state_d = ARB_LOCK;
            owner_d = g_idx;
            cnt_d   = CW'(1);
          end else begin
            ptr_d = (g_idx == PW'(N-1)) ? '0 : g_idx + PW'(1);
          end
        end
      end
      ARB_LOCK: begin
        gnt[owner_q] = iReq[owner_q];
        if (!iReq[owner_q] || !iLock[owner_q] || cnt_q == CW'(MAX_LOCK-1)) begin
          state_d = ARB_IDLE;
          ptr_d   = (owner_q == PW'(N-1)) ? '0 : owner_q + PW'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // No access is issued while reset is held.
    if (!iRst_n) gnt = '0;
  end

  // Encode the one-hot grant and select the winning requester's slice.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) g_idx = PW'(i);
    end
    acc_any   = |gnt;
    acc_wr    = acc_any & iWr[g_idx];
    acc_addr  = iAddr[g_idx*AW +: AW];
    acc_wdata = iWData[g_idx*DW +: DW];
    addr_d    = acc_any ? acc_addr  : addr_q;
    wdata_d   = acc_any ? acc_wdata : wdata_q;
    rd_pend   = gnt & ~iWr;
  end

  // FSM state, pointer, lock counter, held address/data and read pipeline.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rvld1_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rvld1_q <= rd_pend;
    end
  end

`ifdef SRAM_ARB_OREG_EN
  logic          cen_q;
  logic          wen_q;
  logic [DW-1:0] bwen_q;
  logic [N-1:0]  rvld2_q;

  // Registered SRAM controls: the SRAM sees the access one cycle after oGnt.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      bwen_q  <= '1;
      rvld2_q <= '0;
    end else begin
      cen_q   <= ~acc_any;
      wen_q   <= ~acc_wr;
      bwen_q  <= acc_wr ? '0 : '1;
      rvld2_q <= rvld1_q;
    end
  end

  assign oCEn   = cen_q;
  assign oWEn   = wen_q;
  assign oBWEn  = bwen_q;
  assign oAddr  = addr_q;
  assign oWData = wdata_q;
  assign oRVld  = rvld2_q & {N{iRst_n}};
`else
  assign oCEn   = ~acc_any;
  assign oWEn   = ~acc_wr;
  assign oBWEn  = acc_wr ? '0 : '1;
  assign oAddr  = addr_d;
  assign oWData = wdata_d;
  assign oRVld  = rvld1_q & {N{iRst_n}};
`endif

  assign oGnt   = gnt;
  assign oRData = iRData;
  assign oState = state_q;

endmodule
